// File: rtl/uart_bridge_pkg.sv
// Shared definitions for uart_apb_stream_bridge: CoreUARTapb register map,
// STATUS bit positions, bridge FSM states and APB operation codes.
package uart_bridge_pkg;

   localparam logic [4:0] REG_TXDATA = 5'h00;
   localparam logic [4:0] REG_RXDATA = 5'h04;
   localparam logic [4:0] REG_CTRL1  = 5'h08;
   localparam logic [4:0] REG_CTRL2  = 5'h0C;
   localparam logic [4:0] REG_STATUS = 5'h10;

   localparam int unsigned STATUS_TXRDY_BIT   = 0;
   localparam int unsigned STATUS_RXRDY_BIT   = 1;
   localparam int unsigned STATUS_PARITY_BIT  = 2;
   localparam int unsigned STATUS_OVERFLOW_BIT = 3;
   localparam int unsigned STATUS_FRAMING_BIT = 4;

   typedef enum logic [2:0] {
      ST_INIT1  = 3'd0,
      ST_INIT2  = 3'd1,
      ST_IDLE   = 3'd2,
      ST_SETUP  = 3'd3,
      ST_ACCESS = 3'd4,
      ST_GUARD  = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      OP_CFG1 = 3'd0,
      OP_CFG2 = 3'd1,
      OP_TXW  = 3'd2,
      OP_RXR  = 3'd3,
      OP_STR  = 3'd4
   } op_e;

endpackage

// File: rtl/uart_bridge_byte_reg.sv
// Single-entry valid/ready holding register; in_ready is simply !out_valid,
// so a slot freed this cycle can only be refilled on the next.
module uart_bridge_byte_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else if (!valid_q && in_valid) begin
         valid_d = 1'b1;
         data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = !valid_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/uart_apb_stream_bridge.sv
// APB master that programs a CoreUARTapb and bridges its TX/RX data registers
// to byte streams. Optional macro: UART_BRIDGE_ERR_STATUS_EN (STATUS read per RX byte).
module uart_apb_stream_bridge
   import uart_bridge_pkg::*;
#(
   parameter logic [12:0] BAUD_VALUE = 13'd1,
   parameter bit          PRG_BIT8   = 1'b1,
   parameter logic [1:0]  PRG_PARITY = 2'd0,
   parameter bit          CFG_WRITE  = 1'b1
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   output logic [4:0] PADDR,
   output logic       PSEL,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY,
   input  logic       PSLVERR,
   input  logic       TXRDY,
   input  logic       RXRDY,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   output logic       s_tready,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic [2:0] m_terr,
   output logic       init_done,
   output logic       apb_err
);

   localparam state_e     RESET_STATE = CFG_WRITE ? ST_INIT1 : ST_IDLE;
   localparam logic [7:0] CTRL1_VALUE = BAUD_VALUE[7:0];
   localparam logic [7:0] CTRL2_VALUE = {BAUD_VALUE[12:8], PRG_PARITY == 2'd2,
                                         PRG_PARITY != 2'd0, PRG_BIT8};

   state_e      state_q, state_d;
   op_e         op_q, op_d;
   logic        guard_q, guard_d;
   logic [4:0]  paddr_q, paddr_d;
   logic        pwrite_q, pwrite_d;
   logic [7:0]  pwdata_q, pwdata_d;
   logic        init_done_q, init_done_d;
   logic        apb_err_q, apb_err_d;

   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_pop;
   logic        rx_push;
   logic [10:0] rx_push_data;
   logic        rx_in_ready;
   logic [10:0] rx_out_data;
   logic        str_pend;

`ifdef UART_BRIDGE_ERR_STATUS_EN
   logic        str_pend_q, str_pend_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   assign str_pend = str_pend_q;
`else
   assign str_pend = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      guard_d      = guard_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      init_done_d  = init_done_q;
      apb_err_d    = apb_err_q;
      tx_pop       = 1'b0;
      rx_push      = 1'b0;
      rx_push_data = {3'b000, PRDATA};
`ifdef UART_BRIDGE_ERR_STATUS_EN
      str_pend_d   = str_pend_q;
      rx_byte_d    = rx_byte_q;
`endif
      unique case (state_q)
         ST_INIT1: begin
            op_d     = OP_CFG1;
            paddr_d  = REG_CTRL1;
            pwrite_d = 1'b1;
            pwdata_d = CTRL1_VALUE;
            state_d  = ST_SETUP;
         end
         ST_INIT2: begin
            op_d     = OP_CFG2;
            paddr_d  = REG_CTRL2;
            pwrite_d = 1'b1;
            pwdata_d = CTRL2_VALUE;
            state_d  = ST_SETUP;
         end
         ST_IDLE: begin
            // Pending STATUS read first, then RX ahead of TX so the UART cannot overflow.
            if (str_pend) begin
               op_d     = OP_STR;
               paddr_d  = REG_STATUS;
               pwrite_d = 1'b0;
               pwdata_d = '0;
               state_d  = ST_SETUP;
            end else if (RXRDY && rx_in_ready) begin
               op_d     = OP_RXR;
               paddr_d  = REG_RXDATA;
               pwrite_d = 1'b0;
               pwdata_d = '0;
               state_d  = ST_SETUP;
            end else if (TXRDY && tx_valid) begin
               op_d     = OP_TXW;
               paddr_d  = REG_TXDATA;
               pwrite_d = 1'b1;
               pwdata_d = tx_data;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               if (PSLVERR) begin
                  apb_err_d = 1'b1;
               end
               guard_d = 1'b0;
               state_d = ST_GUARD;
               unique case (op_q)
                  OP_TXW: tx_pop = 1'b1;
`ifdef UART_BRIDGE_ERR_STATUS_EN
                  OP_RXR: begin
                     rx_byte_d  = PRDATA;
                     str_pend_d = 1'b1;
                  end
                  OP_STR: begin
                     str_pend_d   = 1'b0;
                     rx_push      = 1'b1;
                     rx_push_data = {PRDATA[STATUS_FRAMING_BIT], PRDATA[STATUS_OVERFLOW_BIT],
                                     PRDATA[STATUS_PARITY_BIT], rx_byte_q};
                  end
`else
                  OP_RXR: rx_push = 1'b1;
`endif
                  default: ;
               endcase
            end
         end
         ST_GUARD: begin
            if (guard_q) begin
               if (op_q == OP_CFG1) begin
                  state_d = ST_INIT2;
               end else begin
                  state_d = ST_IDLE;
                  if (op_q == OP_CFG2) begin
                     init_done_d = 1'b1;
                  end
               end
            end else begin
               guard_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= RESET_STATE;
         op_q        <= OP_CFG1;
         guard_q     <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         init_done_q <= !CFG_WRITE;
         apb_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         guard_q     <= guard_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         init_done_q <= init_done_d;
         apb_err_q   <= apb_err_d;
      end
   end

`ifdef UART_BRIDGE_ERR_STATUS_EN
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         str_pend_q <= 1'b0;
         rx_byte_q  <= '0;
      end else begin
         str_pend_q <= str_pend_d;
         rx_byte_q  <= rx_byte_d;
      end
   end
`endif

   uart_bridge_byte_reg #(.WIDTH(8)) u_tx_reg (
      .clk       (PCLK),
      .rst_n     (PRESETN),
      .in_valid  (s_tvalid),
      .in_ready  (s_tready),
      .in_data   (s_tdata),
      .out_valid (tx_valid),
      .out_ready (tx_pop),
      .out_data  (tx_data)
   );

   uart_bridge_byte_reg #(.WIDTH(11)) u_rx_reg (
      .clk       (PCLK),
      .rst_n     (PRESETN),
      .in_valid  (rx_push),
      .in_ready  (rx_in_ready),
      .in_data   (rx_push_data),
      .out_valid (m_tvalid),
      .out_ready (m_tready),
      .out_data  (rx_out_data)
   );

   assign m_tdata   = rx_out_data[7:0];
   assign m_terr    = rx_out_data[10:8];
   assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE   = (state_q == ST_ACCESS);
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign init_done = init_done_q;
   assign apb_err   = apb_err_q;

endmodule

// File: tb/tb_uart_apb_stream_bridge.sv
// Self-checking bench for uart_apb_stream_bridge with a behavioural CoreUARTapb
// APB slave and scoreboards for APB transfers and the RX output stream.
module tb_uart_apb_stream_bridge;

`ifdef UART_BRIDGE_ERR_STATUS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       PCLK = 1'b0;
   logic       PRESETN;
   logic [4:0] PADDR;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PWDATA, PRDATA;
   logic       PREADY, PSLVERR, TXRDY, RXRDY;
   logic [7:0] s_tdata;
   logic       s_tvalid, s_tready;
   logic [7:0] m_tdata;
   logic       m_tvalid, m_tready;
   logic [2:0] m_terr;
   logic       init_done, apb_err;

   logic       pready_v = 1'b1;
   logic       pslverr_v = 1'b0;
   logic       txrdy_v = 1'b1;
   logic [7:0] status_v = 8'h00;
   logic [7:0] rx_mem [256];
   int         rx_req = 0;
   int         rx_rd = 0;
   bit         rd_inc = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic       wr;
      logic [4:0] addr;
      logic [7:0] data;
   } apb_t;

   apb_t        exp_apb[$];
   logic [10:0] exp_rx[$];

   typedef struct {
      bit         is_rx;
      logic [7:0] data;
      logic [7:0] status;
      logic [2:0] err_stat;
   } vec_t;

   vec_t vecs[8];

   always #5 PCLK = ~PCLK;

   assign PREADY  = pready_v;
   assign PSLVERR = pslverr_v & PSEL & PENABLE;
   assign TXRDY   = txrdy_v;
   assign RXRDY   = (rx_req != rx_rd);
   assign PRDATA  = (PADDR == 5'h04) ? rx_mem[rx_rd[7:0]] :
                    (PADDR == 5'h10) ? status_v : 8'h00;

   uart_apb_stream_bridge #(
      .BAUD_VALUE (13'h0A5),
      .PRG_BIT8   (1'b1),
      .PRG_PARITY (2'd2),
      .CFG_WRITE  (1'b1)
   ) dut (
      .PCLK      (PCLK),
      .PRESETN   (PRESETN),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .TXRDY     (TXRDY),
      .RXRDY     (RXRDY),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_terr    (m_terr),
      .init_done (init_done),
      .apb_err   (apb_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Transfer and stream monitors, sampled on the falling edge.
   always @(negedge PCLK) begin
      apb_t e;
      if (rd_inc) begin
         rx_rd  = rx_rd + 1;
         rd_inc = 1'b0;
      end
      if (PRESETN && PSEL && PENABLE && PREADY) begin
         if (exp_apb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL apb_unexpected: got wr=%0b addr=%0h data=%0h, required no transfer",
                     PWRITE, PADDR, PWDATA);
         end else begin
            e = exp_apb.pop_front();
            chk("apb_pwrite", {31'd0, PWRITE}, {31'd0, e.wr});
            chk("apb_paddr", {27'd0, PADDR}, {27'd0, e.addr});
            if (e.wr) chk("apb_pwdata", {24'd0, PWDATA}, {24'd0, e.data});
         end
         if (!PWRITE && PADDR == 5'h04) rd_inc = 1'b1;
      end
      if (PRESETN && m_tvalid && m_tready) begin
         if (exp_rx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got byte %0h, required no output", m_tdata);
         end else begin
            logic [10:0] r;
            r = exp_rx.pop_front();
            chk("m_tdata", {24'd0, m_tdata}, {24'd0, r[7:0]});
            chk("m_terr", {29'd0, m_terr}, {29'd0, r[10:8]});
         end
      end
   end

   task automatic exp_write(input logic [4:0] a, input logic [7:0] d);
      apb_t e;
      e.wr = 1'b1; e.addr = a; e.data = d;
      exp_apb.push_back(e);
   endtask

   task automatic exp_read(input logic [4:0] a);
      apb_t e;
      e.wr = 1'b0; e.addr = a; e.data = 8'h00;
      exp_apb.push_back(e);
   endtask

   task automatic exp_rx_byte(input logic [7:0] d, input logic [2:0] err_stat, input bit to_stream);
      exp_read(5'h04);
      if (ERR_EN) exp_read(5'h10);
      if (to_stream) exp_rx.push_back({ERR_EN ? err_stat : 3'b000, d});
   endtask

   task automatic rx_push(input logic [7:0] d);
      rx_mem[rx_req[7:0]] = d;
      rx_req = rx_req + 1;
   endtask

   task automatic push_tx(input logic [7:0] d);
      int n = 0;
      @(posedge PCLK); #1;
      s_tdata  = d;
      s_tvalid = 1'b1;
      @(negedge PCLK);
      while (!s_tready && n < 300) begin
         @(negedge PCLK);
         n++;
      end
      chk("tx_accept_timeout", {31'd0, n >= 300}, 32'd0);
      @(posedge PCLK); #1;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input bit incl_rx);
      int n = 0;
      while ((exp_apb.size() != 0 || (incl_rx && exp_rx.size() != 0)) && n < 300) begin
         @(negedge PCLK);
         n++;
      end
      checks++;
      if (n >= 300) begin
         failures++;
         $display("FAIL %s: timeout with %0d apb and %0d rx expected, required 0",
                  name, exp_apb.size(), exp_rx.size());
      end
      repeat (3) @(negedge PCLK);
   endtask

   task automatic check_init(input string name);
      int cyc = 0;
      exp_write(5'h08, 8'hA5);
      exp_write(5'h0C, 8'h07);
      @(posedge PCLK); #1;
      PRESETN = 1'b1;
      while (!init_done && cyc < 60) begin
         @(posedge PCLK);
         cyc++;
         @(negedge PCLK);
      end
      chk(name, cyc, 32'd10);
      wait_drain("init_drain", 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      typedef struct { logic psel; logic pen; logic rdy; } pat_t;
      pat_t pat[6];
      logic [13:0] snap;
      int n;
      int cnt;
      bit hold_ok;

      vecs[0] = '{1'b0, 8'h55, 8'h00, 3'b000};
      vecs[1] = '{1'b1, 8'h3C, 8'h14, 3'b101};
      vecs[2] = '{1'b0, 8'h00, 8'h00, 3'b000};
      vecs[3] = '{1'b0, 8'hFF, 8'h00, 3'b000};
      vecs[4] = '{1'b1, 8'hA5, 8'h10, 3'b100};
      vecs[5] = '{1'b1, 8'h00, 8'h0C, 3'b011};
      vecs[6] = '{1'b0, 8'h81, 8'h00, 3'b000};
      vecs[7] = '{1'b1, 8'hFF, 8'h03, 3'b000};

      pat[0] = '{1'b0, 1'b0, 1'b0};
      pat[1] = '{1'b1, 1'b0, 1'b0};
      pat[2] = '{1'b1, 1'b1, 1'b0};
      pat[3] = '{1'b0, 1'b0, 1'b1};
      pat[4] = '{1'b0, 1'b0, 1'b1};
      pat[5] = '{1'b0, 1'b0, 1'b1};

      s_tdata  = 8'h00;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      PRESETN  = 1'b1;
      #2 PRESETN = 1'b0;
      @(negedge PCLK);
      chk("rst_psel", {31'd0, PSEL}, 32'd0);
      chk("rst_penable", {31'd0, PENABLE}, 32'd0);
      chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
      chk("rst_paddr", {27'd0, PADDR}, 32'd0);
      chk("rst_pwdata", {24'd0, PWDATA}, 32'd0);
      chk("rst_s_tready", {31'd0, s_tready}, 32'd1);
      chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
      chk("rst_m_terr", {29'd0, m_terr}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_apb_err", {31'd0, apb_err}, 32'd0);

      check_init("init_done_cycles");

      // Table of single transactions with a free downstream.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].is_rx) begin
            exp_rx_byte(vecs[i].data, vecs[i].err_stat, 1'b1);
            @(posedge PCLK); #1;
            status_v = vecs[i].status;
            rx_push(vecs[i].data);
         end else begin
            exp_write(5'h00, vecs[i].data);
            push_tx(vecs[i].data);
         end
         wait_drain("vec_drain", 1'b1);
      end

      // TX cycle shape: IDLE, SETUP, ACCESS, GUARD, GUARD, then IDLE.
      exp_write(5'h00, 8'h5A);
      push_tx(8'h5A);
      for (int c = 0; c < 6; c++) begin
         @(negedge PCLK);
         chk($sformatf("tx_shape_c%0d", c), {29'd0, PSEL, PENABLE, s_tready},
             {29'd0, pat[c].psel, pat[c].pen, pat[c].rdy});
      end
      wait_drain("tx_shape_drain", 1'b1);

      // RX blocked downstream: latency, hold, no extra read, TX still served.
      @(posedge PCLK); #1;
      m_tready = 1'b0;
      status_v = 8'h14;
      exp_rx_byte(8'h3C, 3'b101, 1'b1);
      rx_push(8'h3C);
      n = 0;
      @(negedge PCLK);
      while (!m_tvalid && n < 50) begin
         @(posedge PCLK);
         n++;
         @(negedge PCLK);
      end
      chk("rx_latency", n, ERR_EN ? 32'd8 : 32'd3);
      wait_drain("rx_block_read", 1'b0);
      @(posedge PCLK); #1;
      rx_push(8'h77);
      hold_ok = 1'b1;
      repeat (12) begin
         @(negedge PCLK);
         if (!m_tvalid || m_tdata !== 8'h3C || m_terr !== (ERR_EN ? 3'b101 : 3'b000)) hold_ok = 1'b0;
      end
      chk("rx_hold", {31'd0, hold_ok}, 32'd1);
      exp_write(5'h00, 8'hA1);
      push_tx(8'hA1);
      wait_drain("tx_while_rx_blocked", 1'b0);
      chk("rx_still_valid", {31'd0, m_tvalid}, 32'd1);
      exp_rx_byte(8'h77, 3'b101, 1'b1);
      @(posedge PCLK); #1;
      m_tready = 1'b1;
      wait_drain("rx_unblock", 1'b1);

      // RXRDY and TXRDY rise together with a TX byte held: read goes first.
      @(posedge PCLK); #1;
      txrdy_v = 1'b0;
      status_v = 8'h00;
      exp_rx_byte(8'h5E, 3'b000, 1'b1);
      exp_write(5'h00, 8'hC3);
      push_tx(8'hC3);
      repeat (3) @(negedge PCLK);
      chk("tx_held_no_ready", {31'd0, s_tready}, 32'd0);
      @(posedge PCLK); #1;
      txrdy_v = 1'b1;
      rx_push(8'h5E);
      wait_drain("rx_tx_priority", 1'b1);

      // PSLVERR on a TX write sets the sticky flag and the bridge keeps going.
      chk("apb_err_before", {31'd0, apb_err}, 32'd0);
      pslverr_v = 1'b1;
      exp_write(5'h00, 8'h99);
      push_tx(8'h99);
      wait_drain("pslverr_write", 1'b1);
      pslverr_v = 1'b0;
      chk("apb_err_set", {31'd0, apb_err}, 32'd1);
      exp_write(5'h00, 8'h33);
      push_tx(8'h33);
      wait_drain("after_pslverr", 1'b1);
      chk("apb_err_sticky", {31'd0, apb_err}, 32'd1);

      // PREADY low for 4 ACCESS cycles.
      @(posedge PCLK); #1;
      pready_v = 1'b0;
      exp_write(5'h00, 8'h6B);
      push_tx(8'h6B);
      n = 0;
      @(negedge PCLK);
      while (!(PSEL && PENABLE) && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      chk("stall_reach_access", {31'd0, PSEL && PENABLE}, 32'd1);
      snap = {PWRITE, PADDR, PWDATA};
      cnt = 1;
      repeat (3) begin
         @(negedge PCLK);
         if (PSEL && PENABLE && {PWRITE, PADDR, PWDATA} == snap) cnt++;
      end
      @(posedge PCLK); #1;
      pready_v = 1'b1;
      @(negedge PCLK);
      if (PSEL && PENABLE && {PWRITE, PADDR, PWDATA} == snap) cnt++;
      chk("stall_access_cycles", cnt, 32'd5);
      @(negedge PCLK);
      chk("stall_ended", {31'd0, PENABLE}, 32'd0);
      wait_drain("stall_drain", 1'b1);

      // Reset during ACCESS with an RX byte held downstream.
      @(posedge PCLK); #1;
      m_tready = 1'b0;
      exp_rx_byte(8'h99, 3'b000, 1'b0);
      rx_push(8'h99);
      wait_drain("rst_rx_hold", 1'b0);
      chk("rst_rx_held", {31'd0, m_tvalid}, 32'd1);
      @(posedge PCLK); #1;
      pready_v = 1'b0;
      exp_write(5'h00, 8'h12);
      push_tx(8'h12);
      n = 0;
      @(negedge PCLK);
      while (!(PSEL && PENABLE) && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      chk("rst_reach_access", {31'd0, PSEL && PENABLE}, 32'd1);
      #2 PRESETN = 1'b0;
      #1;
      chk("midrst_psel", {31'd0, PSEL}, 32'd0);
      chk("midrst_penable", {31'd0, PENABLE}, 32'd0);
      chk("midrst_pwrite", {31'd0, PWRITE}, 32'd0);
      chk("midrst_paddr", {27'd0, PADDR}, 32'd0);
      chk("midrst_s_tready", {31'd0, s_tready}, 32'd1);
      chk("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("midrst_init_done", {31'd0, init_done}, 32'd0);
      exp_apb.delete();
      exp_rx.delete();
      pready_v = 1'b1;
      m_tready = 1'b1;
      check_init("reinit_done_cycles");
      exp_write(5'h00, 8'hE7);
      push_tx(8'hE7);
      wait_drain("post_reset_tx", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
